// File: rtl/dsp_pipe_pkg.sv
// Shared constants and the stage record for the DSP register-chain blocks.
package dsp_pipe_pkg;

  localparam int MAX_DEPTH    = 4;
  localparam int OCC_W        = 3;
  // Width of the data field carried by every stage; narrower chains zero-extend into it.
  localparam int STAGE_DATA_W = 18;

  typedef struct packed {
    logic                    valid;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_reg.sv
// One pipeline stage: holds a {valid, data} record with clock enable,
// synchronous clear and synchronous active-low reset (reset > clear > enable).
module pipe_reg
  import dsp_pipe_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   ce_i,
  input  logic   clr_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t q_q;
  stage_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (ce_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage register chain with clock enable and flush, a popcount of the
// valid bits and a saturating prime counter; DEPTH=0 is a pure wire bypass.
module pipe_reg_chain
  import dsp_pipe_pkg::*;
#(
  parameter int WIDTH_IN = 18,
  parameter int DEPTH    = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CE,
  input  logic                FLUSH,
  input  logic [WIDTH_IN-1:0] in_data,
  input  logic                in_valid,
  output logic [WIDTH_IN-1:0] out_data,
  output logic                out_valid,
  output logic [OCC_W-1:0]    occupancy,
  output logic                primed
);

  if (DEPTH < 0 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH=%0d outside 0..%0d", DEPTH, MAX_DEPTH);
  end

  if (WIDTH_IN < 1 || WIDTH_IN > STAGE_DATA_W) begin : g_bad_width
    $error("pipe_reg_chain: WIDTH_IN=%0d outside 1..%0d", WIDTH_IN, STAGE_DATA_W);
  end

  if (DEPTH == 0) begin : g_bypass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign occupancy = '0;
    assign primed    = 1'b1;
  end else begin : g_chain
    stage_t            stage_q [DEPTH];
    stage_t            head;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  prime_q;
    logic [OCC_W-1:0]  prime_d;

    always_comb begin
      head       = '0;
      head.valid = in_valid;
      head.data  = STAGE_DATA_W'(in_data);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
        pipe_reg u_stage (
          .clk_i   (CLK),
          .rst_n_i (RST_N),
          .ce_i    (CE),
          .clr_i   (FLUSH),
          .d_i     (head),
          .q_o     (stage_q[k])
        );
      end else begin : g_next
        pipe_reg u_stage (
          .clk_i   (CLK),
          .rst_n_i (RST_N),
          .ce_i    (CE),
          .clr_i   (FLUSH),
          .d_i     (stage_q[k-1]),
          .q_o     (stage_q[k])
        );
      end
    end

    always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
        occ = occ + OCC_W'(stage_q[i].valid);
      end
    end

    // Counts enabled edges since the last reset/flush, stopping at DEPTH.
    always_comb begin
      prime_d = prime_q;
      if (FLUSH) begin
        prime_d = '0;
      end else if (CE && (prime_q != OCC_W'(DEPTH))) begin
        prime_d = prime_q + 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        prime_q <= '0;
      end else begin
        prime_q <= prime_d;
      end
    end

    assign out_data  = stage_q[DEPTH-1].data[WIDTH_IN-1:0];
    assign out_valid = stage_q[DEPTH-1].valid;
    assign occupancy = occ;
    assign primed    = (prime_q == OCC_W'(DEPTH));
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: four instances (DEPTH 0, 2, 3, 4) share stimulus.
module tb_pipe_reg_chain;
  import dsp_pipe_pkg::*;

  localparam int W = 18;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CE;
  logic         FLUSH;
  logic [W-1:0] in_data;
  logic         in_valid;

  logic [W-1:0]     d0_od, d2_od, d3_od, d4_od;
  logic             d0_ov, d2_ov, d3_ov, d4_ov;
  logic [OCC_W-1:0] d0_occ, d2_occ, d3_occ, d4_occ;
  logic             d0_pr, d2_pr, d3_pr, d4_pr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  pipe_reg_chain #(.WIDTH_IN(W), .DEPTH(0)) u_d0 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .in_data(in_data), .in_valid(in_valid),
    .out_data(d0_od), .out_valid(d0_ov), .occupancy(d0_occ), .primed(d0_pr));
  pipe_reg_chain #(.WIDTH_IN(W), .DEPTH(2)) u_d2 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .in_data(in_data), .in_valid(in_valid),
    .out_data(d2_od), .out_valid(d2_ov), .occupancy(d2_occ), .primed(d2_pr));
  pipe_reg_chain #(.WIDTH_IN(W), .DEPTH(3)) u_d3 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .in_data(in_data), .in_valid(in_valid),
    .out_data(d3_od), .out_valid(d3_ov), .occupancy(d3_occ), .primed(d3_pr));
  pipe_reg_chain #(.WIDTH_IN(W), .DEPTH(4)) u_d4 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .in_data(in_data), .in_valid(in_valid),
    .out_data(d4_od), .out_valid(d4_ov), .occupancy(d4_occ), .primed(d4_pr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N    = 1'b0;
    CE       = 1'b0;
    FLUSH    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  // Bubble pattern for the DEPTH=2 instance and its expected outputs per edge.
  logic        bub_v   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] bub_d  [5] = '{18'h7, 18'h8, 18'h9, 18'h0, 18'h0};
  logic        bub_ov  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] bub_od [5] = '{18'h0, 18'h7, 18'h8, 18'h9, 18'h0};
  logic [2:0]  bub_occ [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};

  initial begin
    do_reset();

    chk("rst_d2_data", d2_od, 0);
    chk("rst_d2_vld",  d2_ov, 0);
    chk("rst_d2_occ",  d2_occ, 0);
    chk("rst_d2_prm",  d2_pr, 0);
    chk("rst_d4_occ",  d4_occ, 0);
    chk("rst_d4_prm",  d4_pr, 0);
    chk("rst_d0_prm",  d0_pr, 1);
    chk("rst_d0_occ",  d0_occ, 0);

    // Steady stream 1,2,3,... with every sample valid.
    CE       = 1'b1;
    in_valid = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      in_data = W'(n);
      step();
      chk("stream_d2_vld", d2_ov, (n >= 2) ? 1 : 0);
      if (n >= 2) chk("stream_d2_data", d2_od, n - 1);
      chk("stream_d2_occ", d2_occ, (n >= 2) ? 2 : 1);
      chk("stream_d2_prm", d2_pr, (n >= 2) ? 1 : 0);
      chk("stream_d4_occ", d4_occ, (n >= 4) ? 4 : n);
      chk("stream_d4_prm", d4_pr, (n >= 4) ? 1 : 0);
      if (n >= 4) chk("stream_d4_data", d4_od, n - 3);
    end

    // Bypass follows the input between edges.
    in_data  = 18'h3FFFF;
    in_valid = 1'b1;
    #1;
    chk("byp_hi_data", d0_od, 32'h3FFFF);
    chk("byp_hi_vld",  d0_ov, 1);
    in_data  = 18'h00000;
    in_valid = 1'b0;
    #1;
    chk("byp_lo_data", d0_od, 0);
    chk("byp_lo_vld",  d0_ov, 0);
    chk("byp_prm",     d0_pr, 1);
    chk("byp_occ",     d0_occ, 0);

    // Stall on DEPTH=3: 0xA, 0xB then four CE=0 cycles.
    do_reset();
    CE = 1'b1;
    in_valid = 1'b1;
    in_data = 18'hA; step();
    in_data = 18'hB; step();
    chk("stall_pre_occ", d3_occ, 2);
    CE = 1'b0;
    in_data = 18'hEE;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_occ", d3_occ, 2);
      chk("stall_vld", d3_ov, 0);
      chk("stall_prm", d3_pr, 0);
    end
    CE = 1'b1;
    in_data = 18'hC; step();
    chk("resume1_vld",  d3_ov, 1);
    chk("resume1_data", d3_od, 32'hA);
    chk("resume1_occ",  d3_occ, 3);
    chk("resume1_prm",  d3_pr, 1);
    in_data = 18'hD; step();
    chk("resume2_data", d3_od, 32'hB);
    in_data = 18'hE; step();
    chk("resume3_data", d3_od, 32'hC);

    // Flush while CE is low still clears.
    CE = 1'b0;
    FLUSH = 1'b1;
    step();
    chk("flush_noce_occ", d3_occ, 0);
    chk("flush_noce_prm", d3_pr, 0);
    FLUSH = 1'b0;

    // Flush with CE on a full DEPTH=4 chain; 0x55 must be discarded.
    do_reset();
    CE = 1'b1;
    in_valid = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      in_data = W'(n);
      step();
    end
    chk("full_occ",  d4_occ, 4);
    chk("full_data", d4_od, 1);
    chk("full_prm",  d4_pr, 1);
    FLUSH = 1'b1;
    in_data = 18'h55;
    step();
    chk("flush_occ",  d4_occ, 0);
    chk("flush_vld",  d4_ov, 0);
    chk("flush_prm",  d4_pr, 0);
    chk("flush_data", d4_od, 0);
    FLUSH = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_flush_vld",  d4_ov, 0);
      chk("post_flush_data", d4_od, 0);
    end

    // Reset mid-stream with FLUSH and CE also high.
    do_reset();
    CE = 1'b1;
    in_valid = 1'b1;
    in_data = 18'h10; step();
    in_data = 18'h11; step();
    chk("mid_pre_data", d2_od, 32'h10);
    RST_N = 1'b0;
    FLUSH = 1'b1;
    in_data = 18'h99;
    step();
    chk("mid_rst_data", d2_od, 0);
    chk("mid_rst_vld",  d2_ov, 0);
    chk("mid_rst_occ",  d2_occ, 0);
    chk("mid_rst_prm",  d2_pr, 0);
    RST_N = 1'b1;
    FLUSH = 1'b0;
    in_data = 18'h20; step();
    chk("rel1_vld", d2_ov, 0);
    chk("rel1_occ", d2_occ, 1);
    in_data = 18'h21; step();
    chk("rel2_vld",  d2_ov, 1);
    chk("rel2_data", d2_od, 32'h20);
    in_data = 18'h22; step();
    chk("rel3_data", d2_od, 32'h21);

    // Bubbles: valid 1,0,1 on DEPTH=2.
    do_reset();
    CE = 1'b1;
    for (int e = 0; e < 5; e++) begin
      in_valid = bub_v[e];
      in_data  = bub_d[e];
      step();
      chk("bub_vld", d2_ov, bub_ov[e]);
      if (bub_ov[e]) chk("bub_data", d2_od, bub_od[e]);
      chk("bub_occ", d2_occ, bub_occ[e]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
